// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI-style burst master.
package axi_burst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRESP = 3'd3,
        ST_RADDR = 3'd4,
        ST_RDATA = 3'd5,
        ST_RESP  = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Worst-of merge for BRESP/RRESP: higher encoding is the more severe response.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] w;
        if (a > b) begin
            w = a;
        end else begin
            w = b;
        end
        return w;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI-style single-burst master: one command in, one AW/W/B or AR/R burst out, one response back.
// Channel outputs are registered from the next-state decode, so no READY/VALID input reaches an output combinationally.
module axi_burst_master
    import axi_burst_pkg::*;
#(
    parameter  int ADDR_W    = 12,
    parameter  int DATA_W    = 8,
    parameter  int MAX_BEATS = 16,
    localparam int LEN_W     = $clog2(MAX_BEATS)
) (
    input  logic                          clk,
    input  logic                          a_rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_rw,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic [MAX_BEATS*DATA_W-1:0]   cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_rw,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_proto_err,
    output logic [MAX_BEATS*DATA_W-1:0]   rsp_rdata,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [ADDR_W-1:0]             AWADDR,
    output logic [LEN_W-1:0]              AWLEN,
    output logic                          WVALID,
    input  logic                          WREADY,
    output logic [DATA_W-1:0]             WDATA,
    output logic                          WLAST,
    input  logic                          BVALID,
    output logic                          BREADY,
    input  logic [1:0]                    BRESP,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    output logic [ADDR_W-1:0]             ARADDR,
    output logic [LEN_W-1:0]              ARLEN,
    input  logic                          RVALID,
    output logic                          RREADY,
    input  logic [DATA_W-1:0]             RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RLAST
);

    localparam int             PAY_W   = MAX_BEATS * DATA_W;
    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W:0]      r_cnt;
    logic                r_drain;
    logic [DATA_W-1:0]   r_beats [MAX_BEATS];
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_proto_err;

    logic                r_cmd_ready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_wlast;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_rsp_valid;

    logic                w_cmd_ready_nxt;
    logic                w_awvalid_nxt;
    logic                w_wvalid_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_wlast_nxt;
    logic                w_bready_nxt;
    logic                w_arvalid_nxt;
    logic                w_rready_nxt;
    logic                w_rsp_valid_nxt;

    logic                w_accept;
    logic                w_wbeat;
    logic                w_rbeat;
    logic                w_cnt_at_len;
    logic [LEN_W:0]      w_cnt_nxt;
    logic [PAY_W-1:0]    w_rdata_flat;

    // While in WDATA/RDATA the registered WVALID/RREADY are high, so a beat is just the partner's signal.
    assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
    assign w_wbeat      = (r_state == ST_WDATA) && WREADY;
    assign w_rbeat      = (r_state == ST_RDATA) && RVALID;
    assign w_cnt_at_len = (r_cnt == {1'b0, r_len});

    // State register.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; any RLAST ends a read (normal, early, or after draining an overrun).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = (cmd_rw == RW_WRITE) ? ST_WADDR : ST_RADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WADDR: begin
                if (AWREADY) begin
                    w_state_nxt = ST_WDATA;
                end else begin
                    w_state_nxt = ST_WADDR;
                end
            end
            ST_WDATA: begin
                if (WREADY && w_cnt_at_len) begin
                    w_state_nxt = ST_WRESP;
                end else begin
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WRESP: begin
                if (BVALID) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_RADDR: begin
                if (ARREADY) begin
                    w_state_nxt = ST_RDATA;
                end else begin
                    w_state_nxt = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (RVALID && RLAST) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write beat pointer after this cycle's handshake, used to pre-load the next WDATA.
    always_comb begin
        if (w_wbeat) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Output decode from the next state, so the output registers line up with the state register.
    always_comb begin
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_awvalid_nxt   = (w_state_nxt == ST_WADDR);
        w_wvalid_nxt    = (w_state_nxt == ST_WDATA);
        w_bready_nxt    = (w_state_nxt == ST_WRESP);
        w_arvalid_nxt   = (w_state_nxt == ST_RADDR);
        w_rready_nxt    = (w_state_nxt == ST_RDATA);
        w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
        if (w_state_nxt == ST_WDATA) begin
            w_wdata_nxt = r_beats[w_cnt_nxt[LEN_W-1:0]];
            w_wlast_nxt = (w_cnt_nxt == {1'b0, r_len});
        end else begin
            w_wdata_nxt = '0;
            w_wlast_nxt = 1'b0;
        end
    end

    // Output registers; cmd_ready comes out of reset high because reset lands in IDLE.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_cmd_ready <= 1'b1;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wlast     <= w_wlast_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    // Command capture, beat counter, payload store and response accumulation.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_rw            <= RW_READ;
            r_addr          <= '0;
            r_len           <= '0;
            r_cnt           <= '0;
            r_drain         <= 1'b0;
            r_rsp_resp      <= RESP_OKAY;
            r_rsp_proto_err <= 1'b0;
            for (int i = 0; i < MAX_BEATS; i++) begin
                r_beats[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_rw            <= cmd_rw;
                r_addr          <= cmd_addr;
                r_len           <= cmd_len;
                r_cnt           <= '0;
                r_drain         <= 1'b0;
                r_rsp_resp      <= RESP_OKAY;
                r_rsp_proto_err <= 1'b0;
                for (int i = 0; i < MAX_BEATS; i++) begin
                    r_beats[i] <= (cmd_rw == RW_WRITE) ? cmd_wdata[i*DATA_W +: DATA_W] : '0;
                end
            end else if (w_wbeat) begin
                r_cnt <= w_cnt_nxt;
            end else if ((r_state == ST_WRESP) && BVALID) begin
                r_rsp_resp <= BRESP;
            end else if (w_rbeat && !r_drain) begin
                // Once the last expected beat arrives without RLAST, later beats are dropped until RLAST.
                r_beats[r_cnt[LEN_W-1:0]] <= RDATA;
                r_rsp_resp                <= resp_worst(r_rsp_resp, RRESP);
                r_cnt                     <= r_cnt + CNT_ONE;
                if (RLAST && !w_cnt_at_len) begin
                    r_rsp_proto_err <= 1'b1;
                end else if (!RLAST && w_cnt_at_len) begin
                    r_rsp_proto_err <= 1'b1;
                    r_drain         <= 1'b1;
                end else begin
                    r_rsp_proto_err <= r_rsp_proto_err;
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    for (genvar g = 0; g < MAX_BEATS; g++) begin : g_pack
        assign w_rdata_flat[g*DATA_W +: DATA_W] = r_beats[g];
    end

    // The beat store holds write payload during writes; only reads expose it on rsp_rdata.
    assign rsp_rdata     = (r_rw == RW_READ) ? w_rdata_flat : '0;
    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rw        = r_rw;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_proto_err = r_rsp_proto_err;
    assign AWVALID       = r_awvalid;
    assign AWADDR        = r_addr;
    assign AWLEN         = r_len;
    assign WVALID        = r_wvalid;
    assign WDATA         = r_wdata;
    assign WLAST         = r_wlast;
    assign BREADY        = r_bready;
    assign ARVALID       = r_arvalid;
    assign ARADDR        = r_addr;
    assign ARLEN         = r_len;
    assign RREADY        = r_rready;

endmodule
